// File: rtl/sha3_pkg.sv
// Shared SHA-3 constants, absorb-FSM state type and the pad10*1 word helper.
package sha3_pkg;
    localparam int unsigned STATE_SIZE   = 1600;
    localparam int unsigned Z_WIDTH      = 64;
    localparam logic [7:0]  DOMAIN_BYTE  = 8'h06;
    localparam logic [7:0]  PAD_END_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD    = 2'd1,
        PADONLY = 2'd2
    } sha3_state_e;

    // Byte j is w[8j +: 8]; bytes at or above nbytes are zeroed before padding is ORed in.
    function automatic logic [0:Z_WIDTH-1] pad_word(
        input logic [0:Z_WIDTH-1] data,
        input logic [3:0]         nbytes,
        input logic               put_domain,
        input logic               put_end
    );
        logic [0:Z_WIDTH-1] w;
        for (int j = 0; j < 8; j++) begin
            w[8*j +: 8] = (j < int'(nbytes)) ? data[8*j +: 8] : 8'h00;
            if (put_domain && j == int'(nbytes)) w[8*j +: 8] = w[8*j +: 8] | DOMAIN_BYTE;
            if (put_end && j == 7) w[8*j +: 8] = w[8*j +: 8] | PAD_END_BYTE;
        end
        return w;
    endfunction
endpackage

// File: rtl/sha3_block_buffer.sv
// NW x 64-bit rate-block register file; per-slot writes win over the synchronous clear.
module sha3_block_buffer import sha3_pkg::*; #(
    parameter int unsigned NW = 18
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [NW-1:0]           WR_EN,
    input  logic [0:NW*Z_WIDTH-1]   WR_DATA,
    output logic [0:NW*Z_WIDTH-1]   RD_DATA
);
    logic [0:NW*Z_WIDTH-1] mem;

    always_ff @(posedge CLK) begin
        for (int s = 0; s < int'(NW); s++) begin
            if (WR_EN[s]) begin
                mem[Z_WIDTH*s +: Z_WIDTH] <= WR_DATA[Z_WIDTH*s +: Z_WIDTH];
            end else if (CLR) begin
                mem[Z_WIDTH*s +: Z_WIDTH] <= '0;
            end
        end
    end

    assign RD_DATA = mem;
endmodule

// File: rtl/sha3_padder.sv
// SHA-3 absorb front end: packs 64-bit message words into rate blocks and applies pad10*1.
module sha3_padder import sha3_pkg::*; #(
    parameter int unsigned R_BLOCK_SIZE = 1152
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [0:63]             IN_DATA,
    input  logic                    IN_VALID,
    input  logic                    IN_LAST,
    input  logic [3:0]              IN_BYTES,
    output logic                    IN_READY,
    output logic [0:R_BLOCK_SIZE-1] BLOCK,
    output logic                    BLOCK_VALID,
    output logic                    BLOCK_LAST,
    input  logic                    BLOCK_READY
);
    localparam int unsigned NW = R_BLOCK_SIZE / Z_WIDTH;
    localparam int unsigned CW = $clog2(NW);
    localparam logic [CW-1:0] WCNT_MAX = CW'(NW - 1);

    sha3_state_e state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic pad_q, pad_d;
    logic last_q, last_d;

    logic buf_clr;
    logic [NW-1:0] wr_en;
    logic [0:R_BLOCK_SIZE-1] wr_data;
    logic [3:0] nb_eff;
    logic full_last;

    assign nb_eff    = (IN_BYTES > 4'd8) ? 4'd8 : IN_BYTES;
    assign full_last = (nb_eff == 4'd8);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pad_d   = pad_q;
        last_d  = last_q;
        buf_clr = 1'b0;
        wr_en   = '0;
        wr_data = '0;
        case (state_q)
            FILL: begin
                if (IN_VALID) begin
                    // Slots after the last word are rewritten too, so the end byte lands in slot NW-1.
                    for (int s = 0; s < int'(NW); s++) begin
                        if (s == int'(wcnt_q)) begin
                            wr_en[s] = 1'b1;
                            wr_data[Z_WIDTH*s +: Z_WIDTH] = IN_LAST ?
                                pad_word(IN_DATA, nb_eff, !full_last,
                                         !full_last && s == int'(NW) - 1) : IN_DATA;
                        end else if (IN_LAST && s > int'(wcnt_q)) begin
                            wr_en[s] = 1'b1;
                            wr_data[Z_WIDTH*s +: Z_WIDTH] =
                                pad_word('0, 4'd0, full_last && s == int'(wcnt_q) + 1,
                                         s == int'(NW) - 1);
                        end
                    end
                    if (IN_LAST) begin
                        state_d = HOLD;
                        wcnt_d  = '0;
                        pad_d   = full_last && (wcnt_q == WCNT_MAX);
                        last_d  = !(full_last && (wcnt_q == WCNT_MAX));
                    end else if (wcnt_q == WCNT_MAX) begin
                        state_d = HOLD;
                        wcnt_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            HOLD, PADONLY: begin
                if (BLOCK_READY) begin
                    buf_clr = 1'b1;
                    wcnt_d  = '0;
                    if (pad_q) begin
                        state_d    = PADONLY;
                        pad_d      = 1'b0;
                        last_d     = 1'b1;
                        wr_en[0]   = 1'b1;
                        wr_en[NW-1] = 1'b1;
                        wr_data[0 +: Z_WIDTH] = pad_word('0, 4'd0, 1'b1, 1'b0);
                        wr_data[Z_WIDTH*(NW-1) +: Z_WIDTH] = pad_word('0, 4'd0, 1'b0, 1'b1);
                    end else begin
                        state_d = FILL;
                        last_d  = 1'b0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
        if (RST) begin
            buf_clr = 1'b1;
            wr_en   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
        end
    end

    sha3_block_buffer #(
        .NW(NW)
    ) u_buf (
        .CLK     (CLK),
        .CLR     (buf_clr),
        .WR_EN   (wr_en),
        .WR_DATA (wr_data),
        .RD_DATA (BLOCK)
    );

    assign IN_READY    = !RST && (state_q == FILL);
    assign BLOCK_VALID = !RST && (state_q != FILL);
    assign BLOCK_LAST  = !RST && last_q;
endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder: directed vector table, corner sequences, random messages.
module tb_sha3_padder;
    localparam int RB = 1152;
    localparam int NB = RB / 8;
    typedef logic [0:RB-1] blk_t;

    typedef struct {
        int         nfull;
        int         ib;
        int         exp_blocks;
        int         exp_dom;
        logic [7:0] exp_end;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [0:63] IN_DATA;
    logic        IN_VALID;
    logic        IN_LAST;
    logic [3:0]  IN_BYTES;
    logic        IN_READY;
    blk_t        BLOCK;
    logic        BLOCK_VALID;
    logic        BLOCK_LAST;
    logic        BLOCK_READY;

    sha3_padder #(
        .R_BLOCK_SIZE(RB)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_LAST     (IN_LAST),
        .IN_BYTES    (IN_BYTES),
        .IN_READY    (IN_READY),
        .BLOCK       (BLOCK),
        .BLOCK_VALID (BLOCK_VALID),
        .BLOCK_LAST  (BLOCK_LAST),
        .BLOCK_READY (BLOCK_READY)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] msg[$];
    blk_t exp_blk[$];
    blk_t got_blk[$];
    int hs_cyc[$];
    vec_t vecs[10];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input blk_t act, input blk_t exp);
        n_chk++;
        if (act !== exp) begin
            int k = 0;
            while (k < NB - 1 && act[8*k +: 8] === exp[8*k +: 8]) k++;
            n_fail++;
            $display("FAIL %s: byte %0d is %02h expected %02h", name, k,
                     act[8*k +: 8], exp[8*k +: 8]);
        end
    endtask

    // Reference: append 0x06, zero-fill to a block boundary, OR 0x80 into the very last byte.
    task automatic build_model();
        logic [7:0] p[$];
        blk_t b;
        p = msg;
        p.push_back(8'h06);
        while (p.size() % NB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        exp_blk.delete();
        for (int i = 0; i < p.size() / NB; i++) begin
            for (int k = 0; k < NB; k++) b[8*k +: 8] = p[i*NB + k];
            exp_blk.push_back(b);
        end
    endtask

    task automatic load_msg(input int nfull, input int ib, input bit rnd);
        int len = nfull * 8 + (ib > 8 ? 8 : ib);
        msg.delete();
        for (int k = 0; k < len; k++) msg.push_back(rnd ? 8'($urandom) : 8'h61 + 8'(k));
    endtask

    task automatic drive_word(input int w, input int nfull, input int ib);
        int len = msg.size();
        for (int j = 0; j < 8; j++)
            IN_DATA[8*j +: 8] = (8*w + j < len) ? msg[8*w + j] : 8'($urandom);
        IN_LAST  = (w == nfull);
        IN_BYTES = (w == nfull) ? 4'(ib) : 4'($urandom);
        IN_VALID = 1'b1;
    endtask

    task automatic run_msg(input int nfull, input int ib, input int valid_pct, input int ready_pct);
        int   widx = 0;
        int   got = 0;
        int   cyc = 0;
        bit   stall = 1'b0;
        blk_t prev_blk = '0;
        logic prev_last = 1'b0;
        build_model();
        got_blk.delete();
        hs_cyc.delete();
        while (got < exp_blk.size() && cyc < 4000) begin
            @(negedge CLK);
            cyc++;
            if (stall) begin
                chk1("hold_valid", BLOCK_VALID, 1'b1);
                chk_blk("hold_block", BLOCK, prev_blk);
                chk1("hold_last", BLOCK_LAST, prev_last);
            end
            chk1("ready_excl", IN_READY & BLOCK_VALID, 1'b0);
            if (IN_READY) begin
                if (widx <= nfull && int'($urandom_range(0, 99)) < valid_pct) begin
                    drive_word(widx, nfull, ib);
                    widx++;
                end else begin
                    IN_VALID = 1'b0;
                end
            end else begin
                IN_VALID = 1'($urandom);
                IN_DATA  = {$urandom, $urandom};
                IN_LAST  = 1'($urandom);
                IN_BYTES = 4'($urandom);
            end
            BLOCK_READY = (int'($urandom_range(0, 99)) < ready_pct);
            if (BLOCK_VALID && BLOCK_READY) begin
                chk_blk("block_data", BLOCK, exp_blk[got]);
                chk1("block_last", BLOCK_LAST, got == exp_blk.size() - 1);
                got_blk.push_back(BLOCK);
                hs_cyc.push_back(cyc);
                got++;
            end
            stall     = BLOCK_VALID && !BLOCK_READY;
            prev_blk  = BLOCK;
            prev_last = BLOCK_LAST;
        end
        chkn("run_blocks", got, exp_blk.size());
        @(negedge CLK);
        IN_VALID    = 1'b0;
        BLOCK_READY = 1'b0;
        chk1("post_valid", BLOCK_VALID, 1'b0);
        chk1("post_ready", IN_READY, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t lastb;
        vecs[0] = '{0,  0, 1, 0,   8'h80};
        vecs[1] = '{0,  3, 1, 3,   8'h80};
        vecs[2] = '{17, 7, 1, -1,  8'h86};
        vecs[3] = '{17, 8, 2, 0,   8'h80};
        vecs[4] = '{18, 0, 2, 0,   8'h80};
        vecs[5] = '{0,  8, 1, 8,   8'h80};
        vecs[6] = '{16, 8, 1, 136, 8'h80};
        vecs[7] = '{17, 6, 1, 142, 8'h80};
        vecs[8] = '{18, 6, 2, 6,   8'h80};
        vecs[9] = '{1, 12, 1, 16,  8'h80};

        RST = 1'b1; IN_DATA = '0; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_BYTES = '0;
        BLOCK_READY = 1'b0;
        repeat (3) @(negedge CLK);
        chk1("rst_in_ready", IN_READY, 1'b0);
        chk1("rst_valid", BLOCK_VALID, 1'b0);
        chk1("rst_last", BLOCK_LAST, 1'b0);
        chk_blk("rst_block", BLOCK, '0);
        RST = 1'b0;
        #1;
        chk1("rst_release_ready", IN_READY, 1'b1);

        foreach (vecs[i]) begin
            load_msg(vecs[i].nfull, vecs[i].ib, 1'b0);
            run_msg(vecs[i].nfull, vecs[i].ib, 100, 60);
            chkn("tbl_nblocks", got_blk.size(), vecs[i].exp_blocks);
            if (got_blk.size() > 0) begin
                lastb = got_blk[got_blk.size()-1];
                chkn("tbl_end", int'(lastb[8*(NB-1) +: 8]), int'(vecs[i].exp_end));
                if (vecs[i].exp_dom >= 0)
                    chkn("tbl_dom", int'(lastb[8*vecs[i].exp_dom +: 8]), 32'h06);
            end
        end

        // Pending pad: the padding-only block must follow in the very next cycle.
        load_msg(17, 8, 1'b1);
        run_msg(17, 8, 100, 100);
        if (hs_cyc.size() >= 2) chkn("b2b_gap", hs_cyc[1] - hs_cyc[0], 1);
        else chkn("b2b_count", hs_cyc.size(), 2);

        // Backpressure for 10 cycles with garbage on the input side.
        load_msg(0, 3, 1'b0);
        build_model();
        @(negedge CLK);
        IN_DATA = {8'h61, 8'h62, 8'h63, 40'hDE_AD_BE_EF_55};
        IN_LAST = 1'b1; IN_BYTES = 4'd3; IN_VALID = 1'b1; BLOCK_READY = 1'b0;
        @(negedge CLK);
        chk1("lat_valid", BLOCK_VALID, 1'b1);
        chk1("lat_in_ready", IN_READY, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            chk_blk("bp_block", BLOCK, exp_blk[0]);
            chk1("bp_valid", BLOCK_VALID, 1'b1);
            chk1("bp_last", BLOCK_LAST, 1'b1);
            chk1("bp_in_ready", IN_READY, 1'b0);
            IN_VALID = 1'b1; IN_DATA = {$urandom, $urandom};
            IN_LAST = 1'($urandom); IN_BYTES = 4'($urandom);
            @(negedge CLK);
        end
        chk_blk("bp_accept_block", BLOCK, exp_blk[0]);
        IN_VALID = 1'b0; BLOCK_READY = 1'b1;
        @(negedge CLK);
        BLOCK_READY = 1'b0;
        chk1("bp_resume", IN_READY, 1'b1);
        chk1("bp_drop", BLOCK_VALID, 1'b0);

        // Reset after 5 words, then "abc" must give exactly the clean block.
        for (int w = 0; w < 5; w++) begin
            IN_DATA = {$urandom, $urandom}; IN_LAST = 1'b0; IN_VALID = 1'b1;
            @(negedge CLK);
        end
        IN_VALID = 1'b0; RST = 1'b1;
        #1;
        chk1("mid_rst_in_ready", IN_READY, 1'b0);
        @(negedge CLK);
        chk_blk("mid_rst_block", BLOCK, '0);
        chk1("mid_rst_valid", BLOCK_VALID, 1'b0);
        RST = 1'b0;
        load_msg(0, 3, 1'b0);
        run_msg(0, 3, 100, 100);

        // Reset while holding a block with the pad still pending.
        for (int w = 0; w < 18; w++) begin
            IN_DATA = {$urandom, $urandom}; IN_LAST = (w == 17); IN_BYTES = 4'd8;
            IN_VALID = 1'b1;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        chk1("pend_valid", BLOCK_VALID, 1'b1);
        chk1("pend_last", BLOCK_LAST, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk_blk("pend_rst_block", BLOCK, '0);
        load_msg(0, 3, 1'b0);
        run_msg(0, 3, 100, 100);

        for (int i = 0; i < 25; i++) begin
            int nf = int'($urandom_range(0, 40));
            int ib = int'($urandom_range(0, 15));
            load_msg(nf, ib, 1'b1);
            run_msg(nf, ib, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
